// File: rtl/riscv_pkg.sv
// Shared RV32M encodings and constants for the multiply/divide execute unit.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [31:0] DIV_BY_ZERO_Q = 32'hFFFF_FFFF;
    localparam logic [31:0] INT_MIN       = 32'h8000_0000;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } muldiv_state_t;

endpackage

// File: rtl/muldiv_divider.sv
// Radix-2 restoring divider on unsigned magnitudes, one trial subtract per edge.
// Runs DIV_CYCLES iterations after start, then pulses done for one cycle.
module muldiv_divider #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            abort,
    input  logic [XLEN-1:0] dividend,
    input  logic [XLEN-1:0] divisor,
    output logic            done,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [XLEN-1:0]  rem_q, rem_d;
    logic [XLEN-1:0]  quot_q, quot_d;
    logic [XLEN-1:0]  dvsr_q, dvsr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             run_q, run_d;
    logic             done_q, done_d;
    logic [XLEN:0]    shifted;
    logic [XLEN:0]    diff;

    always_comb begin
        rem_d   = rem_q;
        quot_d  = quot_q;
        dvsr_d  = dvsr_q;
        cnt_d   = cnt_q;
        run_d   = run_q;
        done_d  = 1'b0;
        // The dividend drains MSB-first out of the quotient register into the remainder.
        shifted = {rem_q, quot_q[XLEN-1]};
        diff    = shifted - {1'b0, dvsr_q};
        if (abort) begin
            run_d = 1'b0;
        end else if (start) begin
            rem_d  = '0;
            quot_d = dividend;
            dvsr_d = divisor;
            cnt_d  = CNT_W'(DIV_CYCLES - 1);
            run_d  = 1'b1;
        end else if (run_q) begin
            if (!diff[XLEN]) begin
                rem_d  = diff[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b1};
            end else begin
                rem_d  = shifted[XLEN-1:0];
                quot_d = {quot_q[XLEN-2:0], 1'b0};
            end
            if (cnt_q == '0) begin
                run_d  = 1'b0;
                done_d = 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvsr_q <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvsr_q <= dvsr_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign done      = done_q;
    assign quotient  = quot_q;
    assign remainder = rem_q;

endmodule

// File: rtl/muldiv_unit.sv
// RV32M execute-stage multiply/divide unit: 2-cycle multiply, iterative divide
// with a one-edge fast path for divide-by-zero and signed overflow.
module muldiv_unit #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = XLEN
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            out_stall,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [4:0]      in_rd_address,
    output logic            out_valid,
    output logic [XLEN-1:0] out_data,
    output logic [4:0]      out_rd_address,
    output logic            busy
);

    import riscv_pkg::*;

    muldiv_state_t   state_q, state_d;
    muldiv_op_t      op_q, op_d, op_in;
    logic [XLEN-1:0] a_q, a_d, b_q, b_d;
    logic [4:0]      rd_q, rd_d;
    logic            qneg_q, qneg_d, rneg_q, rneg_d;
    logic [XLEN-1:0] out_data_q, out_data_d;
    logic [4:0]      out_rd_q, out_rd_d;

    logic            accept, in_signed, in_is_rem, b_zero, ovf;
    logic [XLEN-1:0] a_mag, b_mag, fast_res;
    logic            div_start, div_done;
    logic [XLEN-1:0] div_quot, div_rem;
    logic            a_sx, b_sx;
    logic signed [XLEN:0]     a_ext, b_ext;
    logic signed [2*XLEN-1:0] prod;

    assign op_in     = muldiv_op_t'(in_funct3);
    assign accept    = in_valid && in_ready && !flush;
    assign in_signed = (op_in == OP_DIV) || (op_in == OP_REM);
    assign in_is_rem = (op_in == OP_REM) || (op_in == OP_REMU);
    assign b_zero    = (in_rs2_data == '0);
    assign ovf       = in_signed && (in_rs1_data == INT_MIN) && (in_rs2_data == '1);
    assign a_mag     = (in_signed && in_rs1_data[XLEN-1]) ? -in_rs1_data : in_rs1_data;
    assign b_mag     = (in_signed && in_rs2_data[XLEN-1]) ? -in_rs2_data : in_rs2_data;

    always_comb begin
        if (b_zero) fast_res = in_is_rem ? in_rs1_data : DIV_BY_ZERO_Q;
        else        fast_res = in_is_rem ? '0 : INT_MIN;
    end

    // Multiplier works on the latched operands while the FSM sits in MUL.
    always_comb begin
        a_sx = 1'b0;
        b_sx = 1'b0;
        case (op_q)
            OP_MUL, OP_MULH: begin a_sx = a_q[XLEN-1]; b_sx = b_q[XLEN-1]; end
            OP_MULHSU:       a_sx = a_q[XLEN-1];
            default:         ;
        endcase
    end
    assign a_ext = {a_sx, a_q};
    assign b_ext = {b_sx, b_q};
    assign prod  = a_ext * b_ext;

    muldiv_divider #(
        .XLEN       (XLEN),
        .DIV_CYCLES (DIV_CYCLES)
    ) u_divider (
        .clk       (clk),
        .reset     (reset),
        .start     (div_start),
        .abort     (flush),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .done      (div_done),
        .quotient  (div_quot),
        .remainder (div_rem)
    );

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        rd_d       = rd_q;
        qneg_d     = qneg_q;
        rneg_d     = rneg_q;
        out_data_d = out_data_q;
        out_rd_d   = out_rd_q;
        div_start  = 1'b0;
        // Flush outranks everything and must not disturb the held result.
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    op_d   = op_in;
                    a_d    = in_rs1_data;
                    b_d    = in_rs2_data;
                    rd_d   = in_rd_address;
                    qneg_d = in_signed && (in_rs1_data[XLEN-1] ^ in_rs2_data[XLEN-1]);
                    rneg_d = in_signed && in_rs1_data[XLEN-1];
                    if (!in_funct3[2]) begin
                        state_d = MUL;
                    end else if (b_zero || ovf) begin
                        out_data_d = fast_res;
                        out_rd_d   = in_rd_address;
                        state_d    = DONE;
                    end else begin
                        div_start = 1'b1;
                        state_d   = DIV;
                    end
                end
                MUL: begin
                    out_data_d = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
                    out_rd_d   = rd_q;
                    state_d    = DONE;
                end
                DIV: if (div_done) begin
                    if (op_q == OP_REM || op_q == OP_REMU)
                        out_data_d = rneg_q ? -div_rem : div_rem;
                    else
                        out_data_d = qneg_q ? -div_quot : div_quot;
                    out_rd_d = rd_q;
                    state_d  = DONE;
                end
                DONE: if (!out_stall) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            op_q       <= OP_MUL;
            a_q        <= '0;
            b_q        <= '0;
            rd_q       <= '0;
            qneg_q     <= 1'b0;
            rneg_q     <= 1'b0;
            out_data_q <= '0;
            out_rd_q   <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rd_q       <= rd_d;
            qneg_q     <= qneg_d;
            rneg_q     <= rneg_d;
            out_data_q <= out_data_d;
            out_rd_q   <= out_rd_d;
        end
    end

    assign in_ready       = (state_q == IDLE);
    assign busy           = (state_q == MUL) || (state_q == DIV);
    assign out_valid      = (state_q == DONE);
    assign out_data       = out_data_q;
    assign out_rd_address = out_rd_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed RV32M cases plus randomized ops
// compared against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        reset, flush, out_stall, in_valid, in_ready;
    logic [2:0]  in_funct3;
    logic [31:0] in_rs1_data, in_rs2_data;
    logic [4:0]  in_rd_address;
    logic        out_valid, busy;
    logic [31:0] out_data;
    logic [4:0]  out_rd_address;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    muldiv_unit dut (
        .clk            (clk),
        .reset          (reset),
        .flush          (flush),
        .out_stall      (out_stall),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_funct3      (in_funct3),
        .in_rs1_data    (in_rs1_data),
        .in_rs2_data    (in_rs2_data),
        .in_rd_address  (in_rd_address),
        .out_valid      (out_valid),
        .out_data       (out_data),
        .out_rd_address (out_rd_address),
        .busy           (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        int ia, ib;
        longint sa, sb, ua, ub;
        logic [63:0] p;
        logic ovf;
        ia = int'(a); ib = int'(b);
        sa = ia; sb = ib;
        ua = longint'({32'd0, a}); ub = longint'({32'd0, b});
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f < 3'd4) return 2;
        if (b == 0) return 1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return 34;
    endfunction

    // Present one op at a negedge; accept happens on the following posedge.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        in_valid = 1'b1; in_funct3 = f; in_rs1_data = a; in_rs2_data = b; in_rd_address = rd;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, input logic [31:0] exp, input int exp_lat);
        int lat;
        lat = 0;
        issue(f, a, b, rd);
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_data"}, out_data, exp);
        check({tag, "_rd"}, 32'(out_rd_address), 32'(rd));
        @(negedge clk);
        check({tag, "_single"}, 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        string       tag;
        logic [2:0]  f;
        logic [31:0] a, b, exp;
        int          lat;
    } vec_t;

    vec_t vecs[$];
    int   seen;
    logic [31:0] held;

    initial begin
        reset = 1'b1; flush = 1'b0; out_stall = 1'b0; in_valid = 1'b0;
        in_funct3 = '0; in_rs1_data = '0; in_rs2_data = '0; in_rd_address = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_rd", 32'(out_rd_address), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ready", 32'(in_ready), 32'd1);

        vecs.push_back('{"mul", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 2});
        vecs.push_back('{"mulh", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 2});
        vecs.push_back('{"mulhu", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 2});
        vecs.push_back('{"mulhsu", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 2});
        vecs.push_back('{"div", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 34});
        vecs.push_back('{"rem", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 34});
        vecs.push_back('{"divu", 3'd5, 32'd100, 32'd7, 32'd14, 34});
        vecs.push_back('{"remu", 3'd7, 32'd100, 32'd7, 32'd2, 34});
        vecs.push_back('{"divu_z", 3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"remu_z", 3'd7, 32'd5, 32'd0, 32'd5, 1});
        vecs.push_back('{"div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1});
        vecs.push_back('{"rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1});
        foreach (vecs[i])
            run_op(vecs[i].tag, vecs[i].f, vecs[i].a, vecs[i].b, (i == 0) ? 5'd5 : 5'(i), vecs[i].exp, vecs[i].lat);

        // Flush in the middle of a divide: no result may ever appear.
        issue(3'd5, 32'd1000, 32'd3, 5'd9);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_ready", 32'(in_ready), 32'd1);
        check("flush_busy", 32'(busy), 32'd0);
        seen = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("flush_no_valid", 32'(seen), 32'd0);
        run_op("after_flush", 3'd5, 32'd9, 32'd3, 5'd4, 32'd3, 34);

        // Stalled result must hold steady, then drop after one free cycle.
        out_stall = 1'b1;
        issue(3'd0, 32'd6, 32'd7, 5'd12);
        seen = 0;
        while (!out_valid && seen < 10) begin @(negedge clk); seen++; end
        held = out_data;
        check("stall_first", out_data, 32'd42);
        seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid && out_data == held && out_rd_address == 5'd12) seen++;
        end
        check("stall_hold", 32'(seen), 32'd5);
        out_stall = 1'b0;
        @(negedge clk);
        check("stall_release", 32'(out_valid), 32'd0);

        // Flush beats out_stall in DONE.
        out_stall = 1'b1;
        issue(3'd5, 32'd8, 32'd0, 5'd1);
        @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0; out_stall = 1'b0;
        check("flush_done", 32'(out_valid), 32'd0);

        // Randomized ops, with corner operands mixed in.
        for (int n = 0; n < 40; n++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            logic [4:0]  rd;
            f  = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = $urandom;
            rd = 5'($urandom);
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = 32'($urandom_range(1, 20));
                3: a = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rnd%0d_f%0d", n, f), f, a, b, rd, ref_result(f, a, b), ref_latency(f, a, b));
        end

        // Reset in the middle of a divide clears everything.
        issue(3'd4, 32'd12345, 32'd17, 5'd30);
        repeat (6) @(negedge clk);
        reset = 1'b1; flush = 1'b1;
        @(negedge clk);
        reset = 1'b0; flush = 1'b0;
        check("rst_mid_valid", 32'(out_valid), 32'd0);
        check("rst_mid_data", out_data, 32'd0);
        check("rst_mid_rd", 32'(out_rd_address), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_ready", 32'(in_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
